// File: rtl/wishbone_manager.sv
// rtl/wishbone_manager.sv - Wishbone B4 classic single-cycle bus master for mem_read/mem_write requests.
// Optional bus timeout is enabled with the WB_TIMEOUT_EN macro.
module wishbone_manager #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                nRst,
    input  logic                mem_read,
    input  logic                mem_write,
    input  logic [ADDR_W-1:0]   adr_to_mem,
    input  logic [DATA_W-1:0]   data_to_mem,
    input  logic [DATA_W/8-1:0] sel_to_mem,
    output logic [DATA_W-1:0]   data_from_mem,
    output logic                mem_busy,
    output logic                mem_done,
    output logic                mem_err,
    output logic                CYC_O,
    output logic                STB_O,
    output logic                WE_O,
    output logic [ADDR_W-1:0]   ADR_O,
    output logic [DATA_W-1:0]   DAT_O,
    output logic [DATA_W/8-1:0] SEL_O,
    input  logic [DATA_W-1:0]   DAT_I,
    input  logic                ACK_I,
    input  logic                ERR_I
);

    typedef enum logic [1:0] {IDLE, BUS, DONE} state_t;

    state_t                state_q;
    logic                  cyc_q;
    logic                  we_q;
    logic [ADDR_W-1:0]     adr_q;
    logic [DATA_W-1:0]     dat_q;
    logic [DATA_W/8-1:0]   sel_q;
    logic [DATA_W-1:0]     rdata_q;
    logic                  done_q;
    logic                  err_q;

    if (TIMEOUT_CYCLES < 1) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    always_ff @(posedge clk) begin
        if (!nRst) begin
            state_q <= IDLE;
            cyc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef WB_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    // Write wins when both requests are raised together.
                    if (mem_read || mem_write) begin
                        adr_q   <= adr_to_mem;
                        dat_q   <= data_to_mem;
                        sel_q   <= sel_to_mem;
                        we_q    <= mem_write;
                        cyc_q   <= 1'b1;
                        state_q <= BUS;
`ifdef WB_TIMEOUT_EN
                        cnt_q   <= '0;
`endif
                    end
                end
                BUS: begin
                    if (ERR_I) begin
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else if (ACK_I) begin
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                        if (!we_q) begin
                            rdata_q <= DAT_I;
                        end
                    end
`ifdef WB_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        cyc_q   <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_busy      = (state_q != IDLE);
    assign mem_done      = done_q;
    assign mem_err       = err_q;
    assign data_from_mem = rdata_q;
    assign CYC_O         = cyc_q;
    assign STB_O         = cyc_q;
    assign WE_O          = we_q;
    assign ADR_O         = adr_q;
    assign DAT_O         = dat_q;
    assign SEL_O         = sel_q;

endmodule

// File: tb/tb_wishbone_manager.sv
// tb/tb_wishbone_manager.sv - self-checking bench for wishbone_manager with a transaction-level reference model.
module tb_wishbone_manager;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        nRst;
    logic        mem_read, mem_write;
    logic [31:0] adr_to_mem, data_to_mem;
    logic [3:0]  sel_to_mem;
    logic [31:0] data_from_mem;
    logic        mem_busy, mem_done, mem_err;
    logic        CYC_O, STB_O, WE_O;
    logic [31:0] ADR_O, DAT_O;
    logic [3:0]  SEL_O;
    logic [31:0] DAT_I;
    logic        ACK_I, ERR_I;

    int tests = 0;
    int fails = 0;

    wishbone_manager #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .nRst(nRst),
        .mem_read(mem_read), .mem_write(mem_write),
        .adr_to_mem(adr_to_mem), .data_to_mem(data_to_mem), .sel_to_mem(sel_to_mem),
        .data_from_mem(data_from_mem), .mem_busy(mem_busy), .mem_done(mem_done), .mem_err(mem_err),
        .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O),
        .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: one outstanding transaction, tracked by how many bus cycles it has waited.
    logic        e_cyc = 0, e_we = 0, e_busy = 0, e_done = 0, e_err = 0;
    logic [31:0] e_adr = 0, e_dat = 0, e_dfm = 0;
    logic [3:0]  e_sel = 0;
    int          m_wait = 0;

    always @(posedge clk) begin
        if (nRst !== 1'b1) begin
            e_cyc = 0; e_we = 0; e_busy = 0; e_done = 0; e_err = 0;
            e_adr = 0; e_dat = 0; e_dfm = 0; e_sel = 0;
        end else if (e_done) begin
            e_done = 0; e_err = 0; e_busy = 0;
        end else if (e_cyc) begin
            m_wait++;
            if (ERR_I) begin
                e_cyc = 0; e_done = 1; e_err = 1;
            end else if (ACK_I) begin
                e_cyc = 0; e_done = 1;
                if (!e_we) e_dfm = DAT_I;
            end
`ifdef WB_TIMEOUT_EN
            else if (m_wait == TO) begin
                e_cyc = 0; e_done = 1; e_err = 1;
            end
`endif
        end else if (mem_read || mem_write) begin
            e_adr = adr_to_mem; e_dat = data_to_mem; e_sel = sel_to_mem;
            e_we = mem_write; e_cyc = 1; e_busy = 1; m_wait = 0;
        end
    end

    always @(posedge clk) begin
        #1;
        chk("cyc", {31'b0, CYC_O}, {31'b0, e_cyc});
        chk("stb", {31'b0, STB_O}, {31'b0, e_cyc});
        chk("we", {31'b0, WE_O}, {31'b0, e_we});
        chk("adr", ADR_O, e_adr);
        chk("dat_o", DAT_O, e_dat);
        chk("sel", {28'b0, SEL_O}, {28'b0, e_sel});
        chk("rdata", data_from_mem, e_dfm);
        chk("busy", {31'b0, mem_busy}, {31'b0, e_busy});
        chk("done", {31'b0, mem_done}, {31'b0, e_done});
        chk("err", {31'b0, mem_err}, {31'b0, e_err});
    end

    // Issue one request, respond after ack_delay bus cycles; returns negedges from request to mem_done.
    task automatic xfer(input logic rd, input logic wr, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input int ack_delay, input logic ack, input logic err,
                        input logic [31:0] rdat, output int edges);
        int bus_n;
        bus_n = 0;
        edges = -1;
        mem_read = rd; mem_write = wr;
        adr_to_mem = adr; data_to_mem = dat; sel_to_mem = sel;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (mem_done) begin
                edges = n;
                mem_read = 0; mem_write = 0; ACK_I = 0; ERR_I = 0;
                break;
            end
            if (CYC_O) begin
                bus_n++;
                if (bus_n > ack_delay) begin
                    ACK_I = ack; ERR_I = err; DAT_I = rdat;
                end
            end
        end
        if (edges < 0) begin
            tests++; fails++;
            $display("FAIL xfer_timeout: no mem_done within 300 cycles");
            mem_read = 0; mem_write = 0; ACK_I = 0; ERR_I = 0;
        end
    endtask

    int  e;
    logic saw_cyc;

    initial begin
        nRst = 0; mem_read = 1; mem_write = 0;
        adr_to_mem = 32'h40; data_to_mem = 0; sel_to_mem = 4'hF;
        DAT_I = 32'h5555_AAAA; ACK_I = 0; ERR_I = 0;
        saw_cyc = 0;
        repeat (2) begin
            @(negedge clk);
            if (CYC_O) saw_cyc = 1;
        end
        chk("rst_cyc_never", {31'b0, saw_cyc}, 32'd0);
        chk("rst_busy", {31'b0, mem_busy}, 32'd0);
        chk("rst_rdata", data_from_mem, 32'd0);
        mem_read = 0;
        nRst = 1;
        @(negedge clk);

        // Read, slave acks after two wait cycles
        xfer(1, 0, 32'h0000_0040, 32'h0, 4'hF, 2, 1, 0, 32'hCAFE_F00D, e);
        chk("rd_edges", e, 32'd4);
        chk("rd_we", {31'b0, WE_O}, 32'd0);
        chk("rd_adr", ADR_O, 32'h40);
        chk("rd_data", data_from_mem, 32'hCAFE_F00D);
        chk("rd_err", {31'b0, mem_err}, 32'd0);
        @(negedge clk);
        chk("rd_busy_after", {31'b0, mem_busy}, 32'd0);
        chk("rd_done_once", {31'b0, mem_done}, 32'd0);

        // Write with immediate ack
        xfer(0, 1, 32'h0000_0100, 32'h1234_5678, 4'b0011, 0, 1, 0, 32'hFFFF_FFFF, e);
        chk("wr_edges", e, 32'd2);
        chk("wr_we", {31'b0, WE_O}, 32'd1);
        chk("wr_dat", DAT_O, 32'h1234_5678);
        chk("wr_sel", {28'b0, SEL_O}, 32'h3);
        chk("wr_rdata_kept", data_from_mem, 32'hCAFE_F00D);
        @(negedge clk);

        // Read+write conflict, slave raises ERR_I and ACK_I together
        xfer(1, 1, 32'h0000_0200, 32'hA5A5_A5A5, 4'hF, 1, 1, 1, 32'h1111_1111, e);
        chk("cf_edges", e, 32'd3);
        chk("cf_we", {31'b0, WE_O}, 32'd1);
        chk("cf_err", {31'b0, mem_err}, 32'd1);
        @(negedge clk);

        // Read ending in error must not update read data
        xfer(1, 0, 32'h0000_0300, 32'h0, 4'hF, 0, 1, 1, 32'hDEAD_BEEF, e);
        chk("rderr_err", {31'b0, mem_err}, 32'd1);
        chk("rderr_data", data_from_mem, 32'hCAFE_F00D);
        @(negedge clk);

        // Reset in the middle of a bus cycle
        mem_read = 1; adr_to_mem = 32'h44;
        @(negedge clk);
        @(negedge clk);
        chk("mid_in_bus", {31'b0, CYC_O}, 32'd1);
        nRst = 0; mem_read = 0;
        @(negedge clk);
        chk("mid_cyc", {31'b0, CYC_O}, 32'd0);
        chk("mid_done", {31'b0, mem_done}, 32'd0);
        chk("mid_rdata", data_from_mem, 32'd0);
        nRst = 1;
        @(negedge clk);
        xfer(1, 0, 32'h0000_0048, 32'h0, 4'hF, 1, 1, 0, 32'h0BAD_CAFE, e);
        chk("post_rst_edges", e, 32'd3);
        chk("post_rst_data", data_from_mem, 32'h0BAD_CAFE);
        @(negedge clk);

`ifdef WB_TIMEOUT_EN
        xfer(1, 0, 32'h0000_0050, 32'h0, 4'hF, 1000, 1, 0, 32'h0, e);
        chk("to_edges", e, 32'd5);
        chk("to_err", {31'b0, mem_err}, 32'd1);
        chk("to_data", data_from_mem, 32'h0BAD_CAFE);
        @(negedge clk);
`else
        mem_read = 1; adr_to_mem = 32'h50;
        @(negedge clk);
        saw_cyc = 1;
        for (int i = 0; i < 120; i++) begin
            @(negedge clk);
            if (!CYC_O || mem_done) saw_cyc = 0;
        end
        chk("hold_cyc_120", {31'b0, saw_cyc}, 32'd1);
        nRst = 0; mem_read = 0;
        @(negedge clk);
        nRst = 1;
        @(negedge clk);
        chk("hold_cleared", {31'b0, CYC_O}, 32'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
